// File: rtl/uart_host_bridge.sv
// Host-side byte FIFOs between a valid/ready host interface and a UART with sticky
// receive flags; TX strobes are paced on the UART busy signal.
module uart_host_bridge #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       host_tx_valid,
  input  logic [7:0] host_tx_data,
  output logic       host_tx_ready,
  output logic       host_rx_valid,
  output logic [7:0] host_rx_data,
  input  logic       host_rx_ready,
  output logic       rx_overflow,
  output logic [7:0] rx_err_count,
  input  logic       clear_status,
  output logic       uart_transmit,
  output logic [7:0] uart_tx_byte,
  input  logic       uart_is_transmitting,
  input  logic       uart_received,
  input  logic [7:0] uart_rx_byte,
  input  logic       uart_recv_error,
  output logic       uart_recv_ack
);

  // state       | meaning
  // T_IDLE      | waiting for a queued byte and an idle UART
  // T_WAIT_BUSY | strobe issued, waiting for the UART to report busy
  // T_WAIT_DONE | UART transmitting, waiting for busy to fall
  typedef enum logic [1:0] {T_IDLE, T_WAIT_BUSY, T_WAIT_DONE} tx_state_e;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  tx_state_e     state_q, state_d;
  logic [7:0]    tx_mem_q [DEPTH];
  logic [7:0]    tx_mem_d [DEPTH];
  logic [7:0]    rx_mem_q [DEPTH];
  logic [7:0]    rx_mem_d [DEPTH];
  logic [AW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [AW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic          uart_transmit_q, uart_transmit_d;
  logic [7:0]    uart_tx_byte_q, uart_tx_byte_d;
  logic          uart_recv_ack_q, uart_recv_ack_d;
  logic          rx_overflow_q, rx_overflow_d;
  logic [7:0]    rx_err_count_q, rx_err_count_d;
  logic          tx_push, tx_pop, rx_capture, rx_room, rx_push, rx_pop, rx_drop, err_inc;

  assign host_tx_ready = tx_cnt_q < FULL;
  assign host_rx_valid = rx_cnt_q != '0;
  assign host_rx_data  = rx_mem_q[rx_rd_q];
  assign uart_transmit = uart_transmit_q;
  assign uart_tx_byte  = uart_tx_byte_q;
  assign uart_recv_ack = uart_recv_ack_q;
  assign rx_overflow   = rx_overflow_q;
  assign rx_err_count  = rx_err_count_q;

  always_comb begin
    tx_push  = host_tx_valid && host_tx_ready;
    tx_pop   = (state_q == T_IDLE) && (tx_cnt_q != '0) && !uart_is_transmitting;
    tx_mem_d = tx_mem_q;
    tx_wr_d  = tx_wr_q;
    tx_rd_d  = tx_rd_q;
    tx_cnt_d = tx_cnt_q;
    if (tx_push) begin
      tx_mem_d[tx_wr_q] = host_tx_data;
      tx_wr_d = tx_wr_q + AW'(1);
    end
    if (tx_pop) tx_rd_d = tx_rd_q + AW'(1);
    case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + CW'(1);
      2'b01:   tx_cnt_d = tx_cnt_q - CW'(1);
      default: tx_cnt_d = tx_cnt_q;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    uart_transmit_d = 1'b0;
    uart_tx_byte_d  = uart_tx_byte_q;
    case (state_q)
      T_IDLE: begin
        if (tx_pop) begin
          uart_transmit_d = 1'b1;
          uart_tx_byte_d  = tx_mem_q[tx_rd_q];
          state_d         = T_WAIT_BUSY;
        end
      end
      T_WAIT_BUSY: if (uart_is_transmitting) state_d = T_WAIT_DONE;
      T_WAIT_DONE: if (!uart_is_transmitting) state_d = T_IDLE;
      default:     state_d = T_IDLE;
    endcase
  end

  // The ack cycle blocks capture so the still-high sticky flags are not taken twice.
  always_comb begin
    rx_capture      = (uart_received || uart_recv_error) && !uart_recv_ack_q;
    rx_pop          = host_rx_valid && host_rx_ready;
    rx_room         = (rx_cnt_q != FULL) || rx_pop;
    rx_push         = rx_capture && uart_received && rx_room;
    rx_drop         = rx_capture && uart_received && !rx_room;
    err_inc         = rx_capture && uart_recv_error;
    uart_recv_ack_d = rx_capture;
    rx_mem_d        = rx_mem_q;
    rx_wr_d         = rx_wr_q;
    rx_rd_d         = rx_rd_q;
    rx_cnt_d        = rx_cnt_q;
    if (rx_push) begin
      rx_mem_d[rx_wr_q] = uart_rx_byte;
      rx_wr_d = rx_wr_q + AW'(1);
    end
    if (rx_pop) rx_rd_d = rx_rd_q + AW'(1);
    case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + CW'(1);
      2'b01:   rx_cnt_d = rx_cnt_q - CW'(1);
      default: rx_cnt_d = rx_cnt_q;
    endcase
  end

  always_comb begin
    rx_overflow_d  = rx_overflow_q || rx_drop;
    rx_err_count_d = rx_err_count_q;
    if (err_inc && (rx_err_count_q != 8'hFF)) rx_err_count_d = rx_err_count_q + 8'd1;
    if (clear_status) begin
      rx_overflow_d  = rx_drop;
      rx_err_count_d = {7'd0, err_inc};
    end
  end

  always_ff @(posedge clk) begin
    tx_mem_q <= tx_mem_d;
    rx_mem_q <= rx_mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= T_IDLE;
      tx_wr_q         <= '0;
      tx_rd_q         <= '0;
      tx_cnt_q        <= '0;
      rx_wr_q         <= '0;
      rx_rd_q         <= '0;
      rx_cnt_q        <= '0;
      uart_transmit_q <= 1'b0;
      uart_tx_byte_q  <= 8'd0;
      uart_recv_ack_q <= 1'b0;
      rx_overflow_q   <= 1'b0;
      rx_err_count_q  <= 8'd0;
    end else begin
      state_q         <= state_d;
      tx_wr_q         <= tx_wr_d;
      tx_rd_q         <= tx_rd_d;
      tx_cnt_q        <= tx_cnt_d;
      rx_wr_q         <= rx_wr_d;
      rx_rd_q         <= rx_rd_d;
      rx_cnt_q        <= rx_cnt_d;
      uart_transmit_q <= uart_transmit_d;
      uart_tx_byte_q  <= uart_tx_byte_d;
      uart_recv_ack_q <= uart_recv_ack_d;
      rx_overflow_q   <= rx_overflow_d;
      rx_err_count_q  <= rx_err_count_d;
    end
  end

endmodule

// File: doc/uart_host_bridge.md
UART_HOST_BRIDGE -- requirements
Module: uart_host_bridge

Interface
REQ-001 SHALL have parameter DEPTH, default 4, entries per FIFO (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  master clock; all logic on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port host_tx_valid  input  1  host offers a byte to send.
REQ-005 SHALL have port host_tx_data  input  8  byte to send.
REQ-006 SHALL have port host_tx_ready  output  1  TX FIFO not full.
REQ-007 SHALL have port host_rx_valid  output  1  RX FIFO not empty.
REQ-008 SHALL have port host_rx_data  output  8  RX FIFO head byte.
REQ-009 SHALL have port host_rx_ready  input  1  host consumes the head byte.
REQ-010 SHALL have port rx_overflow  output  1  sticky: a received byte was dropped.
REQ-011 SHALL have port rx_err_count  output  8  saturating count of UART receive errors.
REQ-012 SHALL have port clear_status  input  1  clears rx_overflow and rx_err_count.
REQ-013 SHALL have port uart_transmit  output  1  one-cycle transmit strobe to the UART.
REQ-014 SHALL have port uart_tx_byte  output  8  byte presented with the strobe.
REQ-015 SHALL have port uart_is_transmitting  input  1  UART transmitter busy.
REQ-016 SHALL have port uart_received  input  1  sticky UART received flag.
REQ-017 SHALL have port uart_rx_byte  input  8  UART received byte.
REQ-018 SHALL have port uart_recv_error  input  1  sticky UART receive-error flag.
REQ-019 SHALL have port uart_recv_ack  output  1  one-cycle acknowledge clearing both UART sticky flags.

Function
REQ-020 TX FIFO: push on host_tx_valid && host_tx_ready; host_tx_ready = count < DEPTH, combinational from registered count.
REQ-021 RX FIFO: pop on host_rx_valid && host_rx_ready; host_rx_data = head entry, valid whenever count > 0.
REQ-022 FIFO pointers SHALL be log2(DEPTH) bits with natural wrap; count SHALL be log2(DEPTH)+1 bits; simultaneous push and pop on a non-empty, non-full FIFO leaves count unchanged.
REQ-023 TX FSM states SHALL be T_IDLE, T_WAIT_BUSY and T_WAIT_DONE.
REQ-024 T_IDLE: when TX FIFO is non-empty and uart_is_transmitting = 0, register uart_transmit = 1 with uart_tx_byte = head, pop, and go to T_WAIT_BUSY.
REQ-025 uart_transmit SHALL be high for exactly one cycle per byte; uart_tx_byte SHALL hold its value until the next strobe.
REQ-026 T_WAIT_BUSY: go to T_WAIT_DONE when uart_is_transmitting = 1.
REQ-027 T_WAIT_DONE: go to T_IDLE when uart_is_transmitting = 0, so a new strobe is issued no earlier than the cycle after busy falls.
REQ-028 Bytes SHALL reach the UART in push order, with no loss or duplication.
REQ-029 RX capture: in a cycle with (uart_received || uart_recv_error) && uart_recv_ack = 0, uart_recv_ack SHALL be registered high for the next cycle only.
REQ-030 No capture SHALL occur while uart_recv_ack = 1, which prevents double capture while the UART flags are still high.
REQ-031 On capture with uart_received = 1: push uart_rx_byte if the RX FIFO is not full; otherwise drop the byte and set rx_overflow.
REQ-032 A push and a host pop in the same cycle on a full RX FIFO SHALL succeed with no overflow.
REQ-033 On capture with uart_recv_error = 1: increment rx_err_count, saturating at 255; when both flags are set, perform both actions.
REQ-034 clear_status SHALL clear rx_overflow and rx_err_count in the next cycle; if a set or increment coincides with clear_status, the result SHALL be 1 (overflow set, count = 1).

Reset
REQ-035 rst SHALL empty both FIFOs and force the TX FSM to T_IDLE, overriding any other same-cycle event.
REQ-036 Reset values SHALL be: uart_transmit=0, uart_tx_byte=0, uart_recv_ack=0, rx_overflow=0, rx_err_count=0, host_tx_ready=1, host_rx_valid=0.
REQ-037 Reset mid-transmission SHALL abandon the remaining FIFO bytes; after reset, no strobe SHALL issue until uart_is_transmitting = 0.

Verification
REQ-038 Push 0x55, 0xA3 with the UART model idle, busy 40 cycles each -> two strobes carrying 0x55 then 0xA3, the second no earlier than 1 cycle after busy falls.
REQ-039 Push DEPTH+1 bytes back-to-back while uart_is_transmitting=1 -> host_tx_ready low after DEPTH pushes; the extra byte is not accepted.
REQ-040 uart_received held high with rx_byte 0x3C until ack -> exactly one ack pulse; host_rx_valid=1 with data 0x3C.
REQ-041 DEPTH+1 received bytes with host_rx_ready=0 -> FIFO holds the first DEPTH bytes; rx_overflow=1; clear_status returns it to 0.
REQ-042 300 uart_recv_error events -> rx_err_count=255; an event with received and error both set -> byte pushed, count saturated, single ack.
REQ-043 rst asserted while DEPTH bytes are queued -> host_tx_ready=1, host_rx_valid=0, and no further strobes.
